// File: rtl/nios_sys_char_sender.sv
// Avalon-MM slave that queues characters written by the CPU into a small FIFO
// and presents them to fabric logic as a show-ahead valid/ready stream.
module nios_sys_char_sender #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int PTR_W      = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_char,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0] last_char_q, last_char_d;
  logic [31:0]           readdata_q, readdata_d;

  logic wr, push, flush, clr_ovf, pop, full, empty, push_ok, drop;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:DATA_WIDTH];

  // Stream handshake: a character transfers on every rising edge where
  // out_valid and out_ready are both high; out_char/out_valid hold while stalled.
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign out_valid = ~empty;
  assign out_char  = mem_q[rd_ptr_q];

  assign wr      = chipselect & ~write_n;
  assign push    = wr & (address == 2'd0);
  assign clr_ovf = wr & (address == 2'd1) & writedata[2];
  assign flush   = wr & (address == 2'd2) & writedata[0];
  assign pop     = out_valid & out_ready;
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    last_char_d = last_char_q;

    if (push) last_char_d = writedata[DATA_WIDTH-1:0];
    if (drop) overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;

    // Flush discards everything, including a character popped in the same cycle.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = writedata[DATA_WIDTH-1:0];
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0: readdata_d[DATA_WIDTH-1:0] = last_char_q;
      2'd1: begin
        readdata_d[8 +: CNT_W] = count_q;
        readdata_d[2]          = overflow_q;
        readdata_d[1]          = full;
        readdata_d[0]          = empty;
      end
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      last_char_q <= '0;
      readdata_q  <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      last_char_q <= last_char_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata = readdata_q;

endmodule

// File: tb/tb_nios_sys_char_sender.sv
// Directed bench for nios_sys_char_sender: register map, stream ordering,
// overflow, push+pop at full, pointer wrap, flush and asynchronous reset.
module tb_nios_sys_char_sender;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_char;
  logic        out_valid;
  logic        out_ready;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  nios_sys_char_sender #(.DATA_WIDTH(8), .DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // drivers: inputs change on the falling edge, outputs sampled there too
  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic push_char(input logic [7:0] c, input bit expect_accept);
    av_write(2'd0, {24'h0, c});
    if (expect_accept) exp_q.push_back(c);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (!out_valid) break;
      if (exp_q.size() == 0) chk({tag, "_extra"}, 32'(out_char), 32'hFFFF_FFFF);
      else chk(tag, 32'(out_char), 32'(exp_q.pop_front()));
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_valid_low"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  c;
    bit          pop_now;
    bit          push_now;

    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; out_ready = 1'b0;

    // 1 reset
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_char", 32'(out_char), 32'h0);
    av_read(2'd1, rd);
    chk("rst_status", rd, 32'h0000_0001);

    // 2 basic send
    push_char(8'h41, 1'b1);
    push_char(8'h42, 1'b1);
    av_read(2'd1, rd);
    chk("basic_status", rd, 32'h0000_0200);
    chk("basic_head", 32'(out_char), 32'h41);
    av_read(2'd0, rd);
    chk("basic_last", rd, 32'h42);
    drain("basic_out");

    // 3 overflow
    for (int i = 0; i < 8; i++) push_char(8'h30 + 8'(i), 1'b1);
    av_read(2'd1, rd);
    chk("ovf_full_status", rd, 32'h0000_0802);
    push_char(8'h38, 1'b0);
    av_read(2'd1, rd);
    chk("ovf_set_status", rd, 32'h0000_0806);
    av_read(2'd0, rd);
    chk("ovf_last_char", rd, 32'h38);
    drain("ovf_out");
    av_write(2'd1, 32'h4);
    av_read(2'd1, rd);
    chk("ovf_cleared", rd, 32'h0000_0001);
    av_read(2'd2, rd);
    chk("addr2_reads0", rd, 32'h0);
    av_write(2'd3, 32'hFFFF_FFFF);
    av_read(2'd3, rd);
    chk("addr3_reads0", rd, 32'h0);

    // 4 push + pop while full
    for (int i = 0; i < 8; i++) push_char(8'h60 + 8'(i), 1'b1);
    @(negedge clk);
    out_ready = 1'b1;
    chk("pp_head", 32'(out_char), 32'(exp_q.pop_front()));
    address = 2'd0; writedata = 32'h5A; chipselect = 1'b1; write_n = 1'b0;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
    av_read(2'd1, rd);
    chk("pp_status", rd, 32'h0000_0802);
    drain("pp_out");

    // 5 wrap-around with alternating ready
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      out_ready = (i % 2) == 1;
      pop_now   = out_valid && out_ready;
      push_now  = (exp_q.size() < 8) || pop_now;
      if (pop_now) chk("wrap_out", 32'(out_char), 32'(exp_q.pop_front()));
      if (push_now) begin
        c = 8'h80 + 8'(i);
        address = 2'd0; writedata = {24'h0, c}; chipselect = 1'b1; write_n = 1'b0;
        exp_q.push_back(c);
      end else begin
        chipselect = 1'b0; write_n = 1'b1;
      end
    end
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; out_ready = 1'b0;
    drain("wrap_drain");
    av_read(2'd1, rd);
    chk("wrap_status", rd, 32'h0000_0001);

    // 6 flush, then asynchronous reset
    for (int i = 0; i < 5; i++) push_char(8'h11 + 8'(i), 1'b1);
    av_read(2'd1, rd);
    chk("flush_pre_status", rd, 32'h0000_0500);
    av_write(2'd2, 32'h1);
    exp_q.delete();
    chk("flush_valid", 32'(out_valid), 32'h0);
    av_read(2'd1, rd);
    chk("flush_status", rd, 32'h0000_0001);
    av_read(2'd0, rd);
    chk("flush_last_kept", rd, 32'h15);
    for (int i = 0; i < 3; i++) push_char(8'h21 + 8'(i), 1'b1);
    chk("refill_valid", 32'(out_valid), 32'h1);
    chk("refill_head", 32'(out_char), 32'h21);
    @(negedge clk);
    address = 2'd0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_char", 32'(out_char), 32'h0);
    chk("arst_readdata", readdata, 32'h0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    av_read(2'd1, rd);
    chk("arst_status", rd, 32'h0000_0001);
    av_read(2'd0, rd);
    chk("arst_last", rd, 32'h0);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
